// File: rtl/prog_lut_pkg.sv
// Shared types and width helpers for the programmable LUT array.
package prog_lut_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } cfg_state_e;

  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prog_lut_array_if.sv
// Data and configuration bus of prog_lut_array; master drives inputs, slave is the array.
interface prog_lut_array_if #(
  parameter int unsigned N_IN = 2,
  parameter int unsigned N_CH = 4
);
  import prog_lut_pkg::*;

  localparam int unsigned CH_W = width_of(N_CH);

  logic                 in_valid;
  logic [N_CH*N_IN-1:0] in_data;
  logic                 out_valid;
  logic [N_CH-1:0]      out_data;
  logic                 cfg_start;
  logic [CH_W-1:0]      cfg_ch;
  logic                 cfg_valid;
  logic                 cfg_bit;
  logic                 cfg_abort;
  logic                 cfg_busy;
  logic                 cfg_done;

  modport master (
    output in_valid, in_data, cfg_start, cfg_ch, cfg_valid, cfg_bit, cfg_abort,
    input  out_valid, out_data, cfg_busy, cfg_done
  );

  modport slave (
    input  in_valid, in_data, cfg_start, cfg_ch, cfg_valid, cfg_bit, cfg_abort,
    output out_valid, out_data, cfg_busy, cfg_done
  );

endinterface

// File: rtl/prog_lut_array_lut_cell.sv
// One channel's 2^N_IN:1 table selection; purely combinational.
module lut_cell #(
  parameter int unsigned N_IN = 2
) (
  input  logic [(1<<N_IN)-1:0] tbl,
  input  logic [N_IN-1:0]      sel,
  output logic                 y
);

  assign y = tbl[sel];

endmodule

// File: rtl/prog_lut_array.sv
// Multi-channel programmable LUT with registered outputs and a serial,
// atomically committed table-load port.
module prog_lut_array
  import prog_lut_pkg::*;
#(
  parameter int unsigned         N_IN      = 2,
  parameter int unsigned         N_CH      = 4,
  parameter logic [(1<<N_IN)-1:0] RST_TABLE = 4'b1001
) (
  input logic             clk,
  input logic             rst,
  prog_lut_array_if.slave bus
);

  localparam int unsigned DEPTH = 1 << N_IN;
  localparam int unsigned CH_W  = width_of(N_CH);
  localparam int unsigned CNT_W = width_of(DEPTH);

  cfg_state_e       state;
  cfg_state_e       state_next;
  logic [CH_W-1:0]  ch_q;
  logic [CNT_W-1:0] cnt;
  logic [DEPTH-1:0] shadow;
  logic [DEPTH-1:0] tables [N_CH];
  logic [N_CH-1:0]  lut_y;
  logic [N_CH-1:0]  out_data_q;
  logic             out_valid_q;
  logic             start_ok;
  logic             last_bit;

  // Out-of-range channel requests never leave IDLE.
  assign start_ok = bus.cfg_start && (32'(bus.cfg_ch) < N_CH);
  assign last_bit = bus.cfg_valid && (cnt == CNT_W'(DEPTH - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = SHIFT;
      SHIFT: begin
        if (bus.cfg_abort)  state_next = IDLE;
        else if (last_bit)  state_next = COMMIT;
      end
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.cfg_busy = (state != IDLE);
  assign bus.cfg_done = (state == COMMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Bits collect in the shadow; the live table only changes on COMMIT,
  // so a reader sees either the whole old or the whole new function.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_q   <= '0;
      cnt    <= '0;
      shadow <= '0;
      for (int unsigned c = 0; c < N_CH; c++) tables[c] <= RST_TABLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            ch_q   <= bus.cfg_ch;
            cnt    <= '0;
            shadow <= '0;
          end
        end
        SHIFT: begin
          if (!bus.cfg_abort && bus.cfg_valid) begin
            shadow[cnt] <= bus.cfg_bit;
            cnt         <= cnt + 1'b1;
          end
        end
        COMMIT:  tables[ch_q] <= shadow;
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    lut_cell #(.N_IN(N_IN)) u_cell (
      .tbl (tables[c]),
      .sel (bus.in_data[c*N_IN +: N_IN]),
      .y   (lut_y[c])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= lut_y;
      out_valid_q <= bus.in_valid;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_prog_lut_array.sv
// Directed bench for prog_lut_array: vector table plus load/abort/reset sequences.
module tb_prog_lut_array;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_lut_array_if #(.N_IN(2), .N_CH(4)) bus ();
  prog_lut_array_if #(.N_IN(2), .N_CH(3)) bus3 ();

  prog_lut_array #(.N_IN(2), .N_CH(4), .RST_TABLE(4'b1001)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  prog_lut_array #(.N_IN(2), .N_CH(3), .RST_TABLE(4'b1001)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic [3:0] exp_out;
    logic       exp_valid;
  } vec_t;

  vec_t vecs [15];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.in_data  = vecs[i].data;
      bus.in_valid = vecs[i].valid;
      step();
      check($sformatf("vec%0d out_data", i), 32'(bus.out_data), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d out_valid", i), 32'(bus.out_valid), 32'(vecs[i].exp_valid));
    end
  endtask

  // Loads one table; when inject >= 0 a cfg_start for channel 3 rides along with bit 'inject'.
  task automatic load_ch(input logic [1:0] ch, input logic [3:0] bits, input int inject, input string tag);
    bus.cfg_start = 1'b1;
    bus.cfg_ch    = ch;
    step();
    bus.cfg_start = 1'b0;
    check({tag, " busy after start"}, 32'(bus.cfg_busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_bit   = bits[k];
      if (k == inject) begin
        bus.cfg_start = 1'b1;
        bus.cfg_ch    = 2'd3;
      end
      step();
      bus.cfg_start = 1'b0;
      if (k < 3) check($sformatf("%s no early done %0d", tag, k), 32'(bus.cfg_done), 32'd0);
    end
    bus.cfg_valid = 1'b0;
    check({tag, " done pulse"}, 32'(bus.cfg_done), 32'd1);
    step();
    check({tag, " done cleared"}, 32'(bus.cfg_done), 32'd0);
    check({tag, " busy cleared"}, 32'(bus.cfg_busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{8'h00, 1'b1, 4'b1111, 1'b1};
    vecs[1]  = '{8'h55, 1'b1, 4'b0000, 1'b1};
    vecs[2]  = '{8'hAA, 1'b1, 4'b0000, 1'b1};
    vecs[3]  = '{8'hFF, 1'b1, 4'b1111, 1'b1};
    vecs[4]  = '{8'hE4, 1'b1, 4'b1001, 1'b1};
    vecs[5]  = '{8'h00, 1'b0, 4'b1111, 1'b0};
    vecs[6]  = '{8'hFF, 1'b1, 4'b1111, 1'b1};
    vecs[7]  = '{8'h55, 1'b1, 4'b0000, 1'b1};
    vecs[8]  = '{8'h00, 1'b1, 4'b1011, 1'b1};
    vecs[9]  = '{8'h00, 1'b1, 4'b1010, 1'b1};
    vecs[10] = '{8'h00, 1'b1, 4'b1000, 1'b1};
    vecs[11] = '{8'h55, 1'b1, 4'b0001, 1'b1};
    vecs[12] = '{8'hFF, 1'b1, 4'b1111, 1'b1};
    vecs[13] = '{8'h00, 1'b1, 4'b1111, 1'b1};
    vecs[14] = '{8'hE4, 1'b1, 4'b1001, 1'b1};

    bus.in_valid = 1'b0; bus.in_data = '0;
    bus.cfg_start = 1'b0; bus.cfg_ch = '0; bus.cfg_valid = 1'b0;
    bus.cfg_bit = 1'b0; bus.cfg_abort = 1'b0;
    bus3.in_valid = 1'b0; bus3.in_data = '0;
    bus3.cfg_start = 1'b0; bus3.cfg_ch = '0; bus3.cfg_valid = 1'b0;
    bus3.cfg_bit = 1'b0; bus3.cfg_abort = 1'b0;

    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    step();
    step();
    check("reset out_data", 32'(bus.out_data), 32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset cfg_busy", 32'(bus.cfg_busy), 32'd0);
    check("reset cfg_done", 32'(bus.cfg_done), 32'd0);
    rst = 1'b0;

    apply_vecs(0, 5);

    load_ch(2'd2, 4'b1000, -1, "and2");
    apply_vecs(6, 8);

    // Continuous input 01 on all channels while channel 0 becomes OR.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    for (int i = 0; i < 7; i++) begin
      logic [3:0] or_bits;
      or_bits = 4'b1110;
      bus.cfg_start = (i == 0);
      bus.cfg_ch    = 2'd0;
      bus.cfg_valid = (i >= 1 && i <= 4);
      bus.cfg_bit   = (i >= 1 && i <= 4) ? or_bits[i-1] : 1'b0;
      step();
      check($sformatf("atomic out_data %0d", i), 32'(bus.out_data), (i < 6) ? 32'h0 : 32'h1);
      check($sformatf("atomic cfg_done %0d", i), 32'(bus.cfg_done), (i == 4) ? 32'd1 : 32'd0);
    end
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;

    // Abort on channel 3; a trailing bit must not complete the dropped load.
    bus.cfg_start = 1'b1; bus.cfg_ch = 2'd3;
    step();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b1; bus.cfg_bit = 1'b0;
    step();
    step();
    check("abort busy before", 32'(bus.cfg_busy), 32'd1);
    bus.cfg_abort = 1'b1;
    step();
    bus.cfg_abort = 1'b0;
    check("abort busy after", 32'(bus.cfg_busy), 32'd0);
    check("abort no done", 32'(bus.cfg_done), 32'd0);
    step();
    bus.cfg_valid = 1'b0;
    check("abort no done later", 32'(bus.cfg_done), 32'd0);
    check("abort still idle", 32'(bus.cfg_busy), 32'd0);
    apply_vecs(9, 9);

    load_ch(2'd1, 4'b1000, 1, "and1 ign start");
    apply_vecs(10, 12);

    // Reset in the middle of a channel-2 load.
    bus.cfg_start = 1'b1; bus.cfg_ch = 2'd2;
    step();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b1; bus.cfg_bit = 1'b1;
    step();
    step();
    bus.cfg_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst busy", 32'(bus.cfg_busy), 32'd0);
    check("midrst done", 32'(bus.cfg_done), 32'd0);
    check("midrst out_data", 32'(bus.out_data), 32'd0);
    #1;
    rst = 1'b0;
    apply_vecs(13, 14);

    // cfg_ch == N_CH on the 3-channel instance is not a valid target.
    bus3.cfg_start = 1'b1; bus3.cfg_ch = 2'd3;
    step();
    bus3.cfg_start = 1'b0;
    check("range ch3 busy", 32'(bus3.cfg_busy), 32'd0);
    bus3.cfg_start = 1'b1; bus3.cfg_ch = 2'd2;
    step();
    bus3.cfg_start = 1'b0;
    check("range ch2 busy", 32'(bus3.cfg_busy), 32'd1);
    bus3.cfg_abort = 1'b1;
    step();
    bus3.cfg_abort = 1'b0;
    check("range abort busy", 32'(bus3.cfg_busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_lut_array.md
# prog_lut_array

Programmable multi-channel look-up-table logic block: each of N_CH channels evaluates an arbitrary N_IN-input Boolean function through a 2^N_IN:1 selection, with a registered output. Truth tables reset to a parameterised default (XNOR for the 2-input case). They are reloaded at run time through a serial configuration port with atomic commit. It generalises the fixed mux-built gates in the lab set into one reconfigurable, pipelined logic primitive.

## Interface
- N_IN, 2: inputs per LUT; table depth is 2^N_IN bits (N_IN ≥ 1).
- N_CH, 4: independent LUT channels.
- RST_TABLE, 4'b1001: reset truth table, width 2^N_IN, loaded into every channel. Bit k is the output for input pattern k; the default is XNOR. It must be overridden when N_IN ≠ 2.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_data  in  N_CH*N_IN  channel c inputs at bits [c*N_IN +: N_IN].
- out_valid  out  1  registered in_valid.
- out_data  out  N_CH  registered LUT results; bit c belongs to channel c.
- cfg_start  in  1  begin loading the table of channel cfg_ch.
- cfg_ch  in  max(1,$clog2(N_CH))  target channel, sampled with cfg_start.
- cfg_valid  in  1  cfg_bit valid this cycle.
- cfg_bit  in  1  serial table bit, LSB (pattern 0) first.
- cfg_abort  in  1  discard the load in progress.
- cfg_busy  out  1  high in SHIFT and COMMIT.
- cfg_done  out  1  one-cycle pulse in the cycle the commit occurs.

## Operation
- Datapath: out_data[c] <= table[c][in_data[c]] and out_valid <= in_valid on every clk edge. out_data updates even when in_valid=0, but it is meaningful only when out_valid=1.
- FSM states:
  - IDLE: cfg_start=1 latches cfg_ch, clears bit counter and shadow register, and moves to SHIFT. A cfg_ch ≥ N_CH is ignored and the FSM stays in IDLE.
  - SHIFT: each cfg_valid cycle writes shadow[cnt] <= cfg_bit and increments cnt. When the bit at index 2^N_IN−1 is accepted, the FSM moves to COMMIT. cfg_valid with no new bit does nothing.
  - COMMIT: table[ch] <= shadow, cfg_done=1, then back to IDLE. Lasts exactly one cycle.
- cfg_abort in SHIFT returns to IDLE with no table change and no cfg_done. cfg_abort takes priority over cfg_valid in the same cycle. It is ignored in IDLE and COMMIT.
- cfg_start outside IDLE is ignored.
- cfg_valid in IDLE or COMMIT is ignored.
- Channels that are not being loaded are never disturbed.

## Timing
- Reset values:
  - out_data=0, out_valid=0, cfg_busy=0, cfg_done=0.
  - FSM in IDLE; all tables = RST_TABLE; counter and shadow = 0.
- Datapath latency is 1 cycle, with full throughput.
- Configuration takes 2^N_IN accepted bits plus 1 commit cycle. With back-to-back cfg_valid the minimum is cfg_start at t0, bits at t1..t(2^N_IN), and COMMIT/cfg_done at t(2^N_IN + 1).
- Commit visibility:
  - An input sampled in the COMMIT cycle uses the old table.
  - An input sampled in the following cycle uses the new table.
  - No mixed old/new bits are ever visible.
- rst asserted mid-load forces IDLE immediately, drops cfg_busy, and restores every table to RST_TABLE. No cfg_done is produced.
- A new cfg_start is accepted in the cycle after COMMIT, once the FSM is back in IDLE.

## Structure
- Package prog_lut_pkg holds:
  - the FSM state enum (IDLE, SHIFT, COMMIT);
  - a width helper function giving max(1, $clog2(n)) for the cfg_ch and counter widths.
- Sub-module lut_cell: one channel's 2^N_IN:1 combinational selection from a table vector and an N_IN-bit select. It is instantiated N_CH times.
- The table registers, shadow register, FSM and output registers live in prog_lut_array.

## Test plan
- Reset default: with N_IN=2, drive every channel with in_data patterns 00, 01, 10, 11 and in_valid=1 → one cycle later out_data per channel is 1, 0, 0, 1 and out_valid=1.
- Reload to AND: load channel 2 with bits 0,0,0,1, then drive inputs 11 on every channel → ch2 gives 1 and the other channels give 1 (XNOR). With inputs 01, ch2 gives 0 and the others give 0.
- Atomic commit: run a continuous input stream during the load of channel 0 to OR (0,1,1,1) and drive input 01 each cycle → output 0 for inputs sampled up to and including the COMMIT cycle, then 1 from the next sample. cfg_done pulses for exactly one cycle.
- Abort: cfg_start, two bits, then cfg_abort together with cfg_valid → no cfg_done, cfg_busy falls the next cycle, and channel behaviour is unchanged.
- Reset mid-load: assert rst during SHIFT after a previously committed AND on channel 1 → cfg_busy=0 and channel 1 is back to XNOR.
- Ignored requests:
  - cfg_start during SHIFT → no effect, and the original channel loads.
  - cfg_start with cfg_ch=N_CH → the FSM stays in IDLE.
